spi_reg_ctrl: RTL



---
 rtl/spi_reg_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_ctrl.sv
// Transaction controller behind spi_slave: turns received bytes (header, length, data)
// into register-bus reads/writes and prefetches read data into txd_data for the next frame.
module spi_reg_ctrl #(
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 50000,
    parameter int TO_W    = 16
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [7:0]        rxd_data,
    input  logic              rxd_flag,
    output logic [7:0]        txd_data,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    input  logic              bus_ack,
    input  logic [7:0]        bus_rdata,
    output logic              busy,
    output logic              frame_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_WR_WAIT,
        S_WR_BUS,
        S_RD_BUS,
        S_RD_WAIT
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            state;
    logic              rw;
    logic [7:0]        cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              overrun;
    logic [ADDR_W-1:0] next_addr;
    logic              to_hit;

    assign next_addr = bus_addr + ADDR_W'(1);
    assign to_hit    = (to_cnt == TO_LAST);

    // The timeout counter falls back to zero unless a waiting state explicitly advances it,
    // which covers both "clear on rxd_flag" and "clear on state change".
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rw        <= 1'b0;
            cnt       <= 8'h00;
            to_cnt    <= '0;
            overrun   <= 1'b0;
            txd_data  <= 8'h00;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= 8'h00;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            to_cnt    <= '0;
            case (state)
                S_IDLE: begin
                    // A byte arriving in the same cycle as an error pulse is dropped.
                    if (rxd_flag && !frame_err) begin
                        rw       <= rxd_data[7];
                        bus_addr <= rxd_data[ADDR_W-1:0];
                        state    <= S_LEN;
                        busy     <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (rxd_flag) begin
                        if (rxd_data == 8'h00) begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                            txd_data  <= 8'h00;
                        end else begin
                            cnt <= rxd_data;
                            if (rw) begin
                                state <= S_WR_WAIT;
                            end else begin
                                state   <= S_RD_BUS;
                                bus_req <= 1'b1;
                                bus_we  <= 1'b0;
                                overrun <= 1'b0;
                            end
                        end
                    end else if (to_hit) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                        txd_data  <= 8'h00;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_WR_WAIT: begin
                    if (rxd_flag) begin
                        bus_wdata <= rxd_data;
                        state     <= S_WR_BUS;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b1;
                        overrun   <= 1'b0;
                    end else if (to_hit) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                        txd_data  <= 8'h00;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_WR_BUS: begin
                    // A byte landing during a bus cycle (even on the ack cycle) is an overrun.
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (overrun || rxd_flag) begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                            txd_data  <= 8'h00;
                        end else begin
                            bus_addr <= next_addr;
                            cnt      <= cnt - 8'd1;
                            if (cnt == 8'd1) begin
                                state    <= S_IDLE;
                                busy     <= 1'b0;
                                txd_data <= 8'h00;
                            end else begin
                                state <= S_WR_WAIT;
                            end
                        end
                    end else if (rxd_flag) begin
                        overrun <= 1'b1;
                    end
                end
                S_RD_BUS: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (overrun || rxd_flag) begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                            txd_data  <= 8'h00;
                        end else begin
                            txd_data <= bus_rdata;
                            state    <= S_RD_WAIT;
                        end
                    end else if (rxd_flag) begin
                        overrun <= 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    if (rxd_flag) begin
                        bus_addr <= next_addr;
                        cnt      <= cnt - 8'd1;
                        if (cnt == 8'd1) begin
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                            txd_data <= 8'h00;
                        end else begin
                            state   <= S_RD_BUS;
                            bus_req <= 1'b1;
                            bus_we  <= 1'b0;
                            overrun <= 1'b0;
                        end
                    end else if (to_hit) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                        txd_data  <= 8'h00;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
